vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single VRAM controller port of the video engine between two requesters.
- Requester 0 is the character control block (UART RX path). Requester 1 is a second VRAM master, e.g. a scroll/clear or status-line engine.
- Arbitration is round-robin with an optional lock for read-modify-write and burst sequences.
- Drives registered VRAM strobes and routes read data back to the requester that issued the read.

Parameters:
- ADDR_W, 11, VRAM address width, {5'y, 6'x}.
- DATA_W, 8, VRAM data width.
- READ_LAT, 1, cycles from o_vram_ce (read) until i_vram_dout is valid. Legal values: 1 or 2.

Ports:
- i_clk  in  1  system clock (12 MHz).
- i_rst  in  1  synchronous reset, active-high.
- i_req0  in  1  requester 0 access request.
- i_we0  in  1  requester 0 write (1) / read (0).
- i_addr0  in  ADDR_W  requester 0 address.
- i_wdata0  in  DATA_W  requester 0 write data.
- i_lock0  in  1  requester 0 keeps ownership after this access.
- o_gnt0  out  1  requester 0 access accepted this cycle.
- o_rvalid0  out  1  read data valid for requester 0.
- i_req1, i_we1, i_addr1, i_wdata1, i_lock1, o_gnt1, o_rvalid1: same as requester 0, for requester 1.
- o_rdata  out  DATA_W  read data, shared; qualified by o_rvalidN.
- o_vram_addr  out  ADDR_W  VRAM address.
- o_vram_din  out  DATA_W  VRAM write data.
- i_vram_dout  in  DATA_W  VRAM read data.
- o_vram_clk  out  1  VRAM clock; equals i_clk.
- o_vram_ce  out  1  VRAM clock enable.
- o_vram_wre  out  1  VRAM write enable (1 = write).

Behaviour:
- Handshake, valid/ready style:
  - A requester holds reqN, weN, addrN, wdataN and lockN stable until gntN=1.
  - An access transfers on the edge where reqN & gntN.
  - gntN is combinational from the req inputs and registered state. No ready-before-valid dependence: gnt is never asserted without req.
- At most one gnt per cycle. One access is accepted per cycle max, so back-to-back accepts are allowed (throughput 1/cycle).
- State registers:
  - rr_ptr: favoured requester, 0 or 1.
  - owner: NONE, 0 or 1.
- Grant rule when owner=NONE:
  - If only one requester asserts req, it is granted.
  - If both assert req, requester rr_ptr is granted.
- Grant rule when owner=N:
  - Only N may be granted. The other requester waits regardless of its req.
- On every accepted access by N:
  - rr_ptr <= ~N.
  - owner <= lockN ? N : NONE.
- Lock release without an access: if owner=N and reqN=0 and lockN=0, then owner <= NONE next cycle.
- VRAM issue, registered, one cycle after accept:
  - o_vram_ce = 1 for exactly one cycle per accept.
  - o_vram_wre = weN.
  - o_vram_addr = addrN.
  - o_vram_din = wdataN.
  - In idle cycles ce=0 and wre=0; addr and din hold their last values.
- Read return:
  - Issuer id and read flag are pipelined READ_LAT+1 cycles deep.
  - o_rvalidN pulses for 1 cycle, READ_LAT cycles after the ce cycle. Total: READ_LAT+1 cycles after accept.
  - o_rdata = i_vram_dout in that cycle.
  - Writes produce no rvalid.
  - Reads from both requesters may be in flight simultaneously. Returns are in issue order and are never merged.
- Simultaneous events:
  - Release and a new request from the other requester in the same cycle: the other requester is not granted until the cycle after owner becomes NONE.
  - Accept with lock=1 by N while the other requester also requests: the other is still starved until release.
- Reset:
  - All outputs reset to 0: o_gnt0/1, o_rvalid0/1, o_rdata, o_vram_addr, o_vram_din, o_vram_ce, o_vram_wre.
  - rr_ptr <= 0; owner <= NONE.
  - Reads in flight are discarded and no rvalid is issued for them.
  - Reset mid-lock clears ownership.
- o_vram_clk is a direct pass of i_clk, not registered.

Test Plan:
- Single write: req0=1, we0=1, addr0=0x041, wdata0=0x41 after reset -> gnt0=1 same cycle; next cycle ce=1, wre=1, addr=0x041, din=0x41; ce=0 afterwards; no rvalid.
- Read latency (READ_LAT=1): VRAM model preloaded 0x5A at 0x7FF; req1 read 0x7FF -> gnt1 at cycle T; ce at T+1; o_rvalid1=1 and o_rdata=0x5A at T+2; o_rvalid0 stays 0.
- Round-robin: req0 and req1 held continuously with 4 writes each -> grant sequence 0,1,0,1,0,1,0,1; one ce per cycle; addresses issued in the same order.
- Lock: req0 read with lock0=1, then a write with lock0=0, while req1 is asserted throughout -> gnt1 stays 0 until after the unlocked write accept; gnt1 in the following cycle.
- Lock release without access: owner=1 is established, then req1=0 and lock1=0 while req0=1 -> owner cleared the next cycle; gnt0 the cycle after that.
- Reset mid-read: i_rst asserted the cycle after a read accept -> ce, wre and both rvalid stay 0 after reset; no stale rvalid; rr_ptr=0, so with both requesting, gnt0 comes first.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin two-requester VRAM port arbiter with lock, registered strobes and read return routing
module vram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_lock0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [DATA_W-1:0] o_vram_din,
  input  logic [DATA_W-1:0] i_vram_dout,
  output logic              o_vram_clk,
  output logic              o_vram_ce,
  output logic              o_vram_wre
);
  typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;
  owner_t owner, owner_nx;
  logic rr_ptr, acc, sel, sel_we, rel;
  logic [READ_LAT:0] rd_v, rd_id;
  assign o_vram_clk = i_clk;
  always_comb begin
    o_gnt0 = !i_rst && i_req0 && (owner == OWN0 || (owner == NONE && (!i_req1 || !rr_ptr)));
    o_gnt1 = !i_rst && i_req1 && (owner == OWN1 || (owner == NONE && (!i_req0 || rr_ptr)));
    acc = o_gnt0 || o_gnt1;
    sel = o_gnt1;
    sel_we = sel ? i_we1 : i_we0;
    rel = (owner == OWN0 && !i_req0 && !i_lock0) || (owner == OWN1 && !i_req1 && !i_lock1);
    owner_nx = acc ? ((sel ? i_lock1 : i_lock0) ? (sel ? OWN1 : OWN0) : NONE) : rel ? NONE : owner;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner       <= NONE;
      rr_ptr      <= 1'b0;
      o_vram_ce   <= 1'b0;
      o_vram_wre  <= 1'b0;
      o_vram_addr <= '0;
      o_vram_din  <= '0;
      rd_v        <= '0;
      rd_id       <= '0;
    end else begin
      owner      <= owner_nx;
      o_vram_ce  <= acc;
      o_vram_wre <= acc && sel_we;
      rd_v       <= {rd_v[READ_LAT-1:0], acc && !sel_we};
      rd_id      <= {rd_id[READ_LAT-1:0], sel};
      if (acc) begin
        rr_ptr      <= !sel;
        o_vram_addr <= sel ? i_addr1 : i_addr0;
        o_vram_din  <= sel ? i_wdata1 : i_wdata0;
      end
    end
  end
  assign o_rvalid0 = !i_rst && rd_v[READ_LAT] && !rd_id[READ_LAT];
  assign o_rvalid1 = !i_rst && rd_v[READ_LAT] && rd_id[READ_LAT];
  assign o_rdata   = (o_rvalid0 || o_rvalid1) ? i_vram_dout : '0;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter
module tb_vram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, we0 = 0, lock0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [10:0] addr0 = '0, addr1 = '0, vaddr;
  logic [7:0] wdata0 = '0, wdata1 = '0, rdata, vdin, vdout = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, vclk, vce, vwre;
  logic [7:0] mem [0:2047];
  int checks = 0, failures = 0, i0, i1;
  always #5 clk = ~clk;
  vram_arbiter #(.ADDR_W(11), .DATA_W(8), .READ_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .i_lock0(lock0),
    .o_gnt0(gnt0), .o_rvalid0(rvalid0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .i_lock1(lock1),
    .o_gnt1(gnt1), .o_rvalid1(rvalid1),
    .o_rdata(rdata), .o_vram_addr(vaddr), .o_vram_din(vdin), .i_vram_dout(vdout),
    .o_vram_clk(vclk), .o_vram_ce(vce), .o_vram_wre(vwre)
  );
  always @(posedge clk)
    if (vce) begin
      if (vwre) mem[vaddr] <= vdin;
      else vdout <= mem[vaddr];
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    mem[11'h7FF] = 8'h5A;
    mem[11'h010] = 8'h33;
    req0 = 1;
    tick();
    tick();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_ce", vce, 0);
    chk("rst_wre", vwre, 0);
    chk("rst_addr", vaddr, 0);
    chk("rst_din", vdin, 0);
    chk("rst_rv", {rvalid0, rvalid1}, 0);
    chk("rst_rdata", rdata, 0);
    req0 = 0;
    rst = 0;
    tick();
    // single write
    req0 = 1; we0 = 1; addr0 = 11'h041; wdata0 = 8'h41;
    #1;
    chk("wr_gnt0", gnt0, 1);
    chk("wr_gnt1", gnt1, 0);
    tick();
    req0 = 0;
    chk("wr_ce", vce, 1);
    chk("wr_wre", vwre, 1);
    chk("wr_addr", vaddr, 11'h041);
    chk("wr_din", vdin, 8'h41);
    tick();
    chk("wr_ce_off", vce, 0);
    chk("wr_wre_off", vwre, 0);
    chk("wr_norv", {rvalid0, rvalid1}, 0);
    chk("wr_hold_addr", vaddr, 11'h041);
    // read latency on requester 1
    req1 = 1; we1 = 0; addr1 = 11'h7FF;
    #1;
    chk("rd_gnt1", gnt1, 1);
    chk("rd_gnt0", gnt0, 0);
    tick();
    req1 = 0;
    chk("rd_ce", vce, 1);
    chk("rd_wre", vwre, 0);
    chk("rd_addr", vaddr, 11'h7FF);
    chk("rd_rv_early", rvalid1, 0);
    tick();
    chk("rd_rv1", rvalid1, 1);
    chk("rd_rv0", rvalid0, 0);
    chk("rd_data", rdata, 8'h5A);
    tick();
    chk("rd_rv1_off", rvalid1, 0);
    // round robin, rr_ptr is 0 after requester 1's access
    i0 = 0; i1 = 0;
    req0 = 1; we0 = 1; req1 = 1; we1 = 1;
    for (int k = 0; k < 8; k++) begin
      addr0 = 11'h100 + 11'(i0); wdata0 = 8'(i0);
      addr1 = 11'h200 + 11'(i1); wdata1 = 8'h80 + 8'(i1);
      #1;
      chk("rr_gnt0", gnt0, (k % 2) == 0);
      chk("rr_gnt1", gnt1, (k % 2) == 1);
      tick();
      chk("rr_ce", vce, 1);
      chk("rr_addr", vaddr, (k % 2) ? 11'h200 + 11'(i1) : 11'h100 + 11'(i0));
      if (k % 2) i1++; else i0++;
      if (i0 == 4) req0 = 0;
    end
    req1 = 0;
    tick();
    chk("rr_ce_off", vce, 0);
    chk("rr_mem", mem[11'h203], 8'h83);
    // lock: requester 0 locked read then unlocked write, requester 1 waiting
    req1 = 1; we1 = 1; addr1 = 11'h300; wdata1 = 8'hC3;
    req0 = 1; we0 = 0; addr0 = 11'h010; lock0 = 1;
    #1;
    chk("lk_gnt0_a", gnt0, 1);
    chk("lk_gnt1_a", gnt1, 0);
    tick();
    we0 = 1; addr0 = 11'h011; wdata0 = 8'h11; lock0 = 0;
    #1;
    chk("lk_gnt0_b", gnt0, 1);
    chk("lk_gnt1_b", gnt1, 0);
    tick();
    req0 = 0;
    #1;
    chk("lk_gnt1_c", gnt1, 1);
    chk("lk_rv0", rvalid0, 1);
    chk("lk_rdata", rdata, 8'h33);
    tick();
    req1 = 0;
    chk("lk_addr", vaddr, 11'h300);
    // release without access: owner=1 then requester 1 drops req and lock
    req1 = 1; we1 = 1; addr1 = 11'h400; lock1 = 1;
    #1;
    chk("rl_gnt1", gnt1, 1);
    tick();
    req1 = 0; lock1 = 0; req0 = 1; we0 = 1; addr0 = 11'h401;
    #1;
    chk("rl_gnt0_blocked", gnt0, 0);
    tick();
    chk("rl_ce_idle", vce, 0);
    chk("rl_gnt0", gnt0, 1);
    tick();
    req0 = 0;
    chk("rl_addr", vaddr, 11'h401);
    // reset mid-read; rr_ptr is 1 before reset
    req0 = 1; we0 = 0; addr0 = 11'h7FF;
    #1;
    chk("mr_gnt0", gnt0, 1);
    tick();
    req0 = 0; rst = 1;
    chk("mr_ce_pre", vce, 1);
    tick();
    chk("mr_ce", vce, 0);
    chk("mr_rv", {rvalid0, rvalid1}, 0);
    rst = 0;
    tick();
    chk("mr_rv2", {rvalid0, rvalid1}, 0);
    chk("mr_wre", vwre, 0);
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    #1;
    chk("mr_gnt0", gnt0, 1);
    chk("mr_gnt1", gnt1, 0);
    tick();
    req0 = 0; req1 = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
